// File: rtl/crayon_pkg.sv
// Types and helpers shared between the rectangle renderer and the rectangle extractor.
package crayon_pkg;

  localparam int unsigned H_ACTIVE_DEFAULT = 1280;
  localparam int unsigned V_ACTIVE_DEFAULT = 720;
  localparam int unsigned X_W              = 11;
  localparam int unsigned Y_W              = 10;
  localparam int unsigned COORD_W          = 2 * (X_W + Y_W) * 2;

  // x_2/y_2 are exclusive bounds: the renderer draws x_1 <= h < x_2.
  typedef struct packed {
    logic [X_W-1:0] x_1;
    logic [Y_W-1:0] y_1;
    logic [X_W-1:0] x_2;
    logic [Y_W-1:0] y_2;
  } rect_t;

  function automatic logic [COORD_W-1:0] pack_rect_coord(input rect_t r);
    return {r.x_1, r.y_1, r.x_2, r.y_1, r.x_1, r.y_2, r.x_2, r.y_2};
  endfunction

endpackage

// File: rtl/rect_extract_bbox_accum.sv
// Min/max/count accumulator. The *_out values are the accumulators merged with the current
// sample, so the end-of-frame pixel is included in the result loaded on the same cycle.
module bbox_accum
  import crayon_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int unsigned COUNT_W  = 21
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,       // sample is a flagged pixel to include
  input  logic               restart_in,  // start from empty before merging the sample
  input  logic               flush_in,    // go empty after presenting the merged result
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  output logic [X_W-1:0]     xmin_out,
  output logic [Y_W-1:0]     ymin_out,
  output logic [X_W-1:0]     xmax_out,
  output logic [Y_W-1:0]     ymax_out,
  output logic [COUNT_W-1:0] count_out
);

  localparam logic [X_W-1:0] XInit = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] YInit = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0]     xmin_q, xmax_q, base_xmin, base_xmax;
  logic [Y_W-1:0]     ymin_q, ymax_q, base_ymin, base_ymax;
  logic [COUNT_W-1:0] count_q, base_count;

  always_comb begin
    base_xmin  = restart_in ? XInit : xmin_q;
    base_ymin  = restart_in ? YInit : ymin_q;
    base_xmax  = restart_in ? '0 : xmax_q;
    base_ymax  = restart_in ? '0 : ymax_q;
    base_count = restart_in ? '0 : count_q;
    xmin_out   = base_xmin;
    ymin_out   = base_ymin;
    xmax_out   = base_xmax;
    ymax_out   = base_ymax;
    count_out  = base_count;
    if (en_in) begin
      if (x_in < base_xmin) xmin_out = x_in;
      if (y_in < base_ymin) ymin_out = y_in;
      if (x_in > base_xmax) xmax_out = x_in;
      if (y_in > base_ymax) ymax_out = y_in;
      if (base_count != '1) count_out = base_count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      xmin_q  <= XInit;
      ymin_q  <= YInit;
      xmax_q  <= '0;
      ymax_q  <= '0;
      count_q <= '0;
    end else if (flush_in) begin
      xmin_q  <= XInit;
      ymin_q  <= YInit;
      xmax_q  <= '0;
      ymax_q  <= '0;
      count_q <= '0;
    end else begin
      xmin_q  <= xmin_out;
      ymin_q  <= ymin_out;
      xmax_q  <= xmax_out;
      ymax_q  <= ymax_out;
      count_q <= count_out;
    end
  end

endmodule

// File: rtl/rect_extract.sv
// Scans a frame's pixel mask in raster order and hands the bounding rectangle of the flagged
// pixels to the consumer through a valid/ready result register.
module rect_extract
  import crayon_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned COUNT_W    = 21
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [X_W-1:0]     hcount_in,
  input  logic [Y_W-1:0]     vcount_in,
  input  logic               valid_in,
  input  logic               mask_in,
  input  logic               rect_ready_in,
  output logic               rect_valid_out,
  output logic               found_out,
  output logic [X_W-1:0]     x_1_out,
  output logic [Y_W-1:0]     y_1_out,
  output logic [X_W-1:0]     x_2_out,
  output logic [Y_W-1:0]     y_2_out,
  output logic [COORD_W-1:0] rect_coord,
  output logic [COUNT_W-1:0] pix_count_out,
  output logic               overrun_out
);

  if (H_ACTIVE > 2047) begin : g_h_range
    $error("H_ACTIVE must not exceed 2047 so that xmax+1 fits the x field");
  end

  localparam logic [0:0]     StSync  = 1'b0;
  localparam logic [0:0]     StAccum = 1'b1;
  localparam logic [X_W-1:0] HLast   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] VLast   = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0]     h_q;
  logic [Y_W-1:0]     v_q;
  logic               valid_q, mask_q;
  logic [0:0]         state_q, state_d;
  logic               start, eof, in_accum, acc_en, acc_flush;
  logic [X_W-1:0]     m_xmin, m_xmax;
  logic [Y_W-1:0]     m_ymin, m_ymax;
  logic [COUNT_W-1:0] m_count;
  logic               found_new;

  rect_t              res_q, res_d;
  logic               found_q, found_d, rvalid_q, rvalid_d, overrun_q, overrun_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
      mask_q  <= 1'b0;
    end else begin
      h_q     <= hcount_in;
      v_q     <= vcount_in;
      valid_q <= valid_in;
      mask_q  <= mask_in;
    end
  end

  // A (0,0) sample always starts a fresh frame, whether syncing or resyncing mid-frame.
  assign start     = valid_q && (h_q == '0) && (v_q == '0);
  assign eof       = valid_q && (h_q == HLast) && (v_q == VLast);
  assign in_accum  = (state_q == StAccum);
  assign acc_en    = valid_q && mask_q && (in_accum || start);
  assign acc_flush = in_accum && eof && !start;
  assign state_d   = start ? StAccum : state_q;

  bbox_accum #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COUNT_W  (COUNT_W)
  ) u_bbox_accum (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (acc_en),
    .restart_in (start),
    .flush_in   (acc_flush),
    .x_in       (h_q),
    .y_in       (v_q),
    .xmin_out   (m_xmin),
    .ymin_out   (m_ymin),
    .xmax_out   (m_xmax),
    .ymax_out   (m_ymax),
    .count_out  (m_count)
  );

  assign found_new = (m_count >= COUNT_W'(MIN_PIXELS));

  always_comb begin
    res_d     = res_q;
    found_d   = found_q;
    count_d   = count_q;
    rvalid_d  = rvalid_q;
    overrun_d = 1'b0;
    if (acc_flush) begin
      rvalid_d  = 1'b1;
      overrun_d = rvalid_q && !rect_ready_in;
      found_d   = found_new;
      count_d   = m_count;
      res_d     = '0;
      if (found_new) begin
        res_d.x_1 = m_xmin;
        res_d.y_1 = m_ymin;
        res_d.x_2 = m_xmax + X_W'(1);
        res_d.y_2 = m_ymax + Y_W'(1);
      end
    end else if (rvalid_q && rect_ready_in) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StSync;
      res_q     <= '0;
      found_q   <= 1'b0;
      count_q   <= '0;
      rvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      found_q   <= found_d;
      count_q   <= count_d;
      rvalid_q  <= rvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rect_valid_out = rvalid_q;
  assign found_out      = found_q;
  assign x_1_out        = res_q.x_1;
  assign y_1_out        = res_q.y_1;
  assign x_2_out        = res_q.x_2;
  assign y_2_out        = res_q.y_2;
  assign rect_coord     = pack_rect_coord(res_q);
  assign pix_count_out  = count_q;
  assign overrun_out    = overrun_q;

endmodule
